thread_scheduler: RTL
=====================

# thread_scheduler

Round-robin issue scheduler for the four-thread barrel fetch stage. Owns the per-thread program counters and active flags, skips threads that are halted or stalled, and presents one registered (thread_id, PC) issue slot per cycle to instruction memory with a valid/ready handshake. Branch resolution, configuration writes and halts from later stages update the per-thread state with fixed priorities.

## Interface
- INSTMEM_LOG2_DEEP, 8, PC width in bits (instruction memory depth = 2^INSTMEM_LOG2_DEEP)
- RESET_ACTIVE, 4'b1111, active mask loaded at reset (bit n = thread n)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- cfg_we_i  in  1  configuration write strobe
- cfg_tid_i  in  2  thread targeted by the configuration write
- cfg_pc_i  in  INSTMEM_LOG2_DEEP  start PC for the configuration write
- halt_i  in  1  halt strobe
- halt_tid_i  in  2  thread to halt
- redir_valid_i  in  1  branch redirect strobe
- redir_tid_i  in  2  thread being redirected
- redir_pc_i  in  INSTMEM_LOG2_DEEP  redirect target PC
- stall_i  in  4  per-thread level stall, bit n = thread n ineligible this cycle
- issue_ready_i  in  1  downstream accepts the issue slot
- issue_valid_o  out  1  issue slot holds a valid thread/PC
- thread_id  out  2  issued thread
- PC_select  out  INSTMEM_LOG2_DEEP  issued PC
- active_o  out  4  current active mask

## Operation
- State: pc[0..3] (INSTMEM_LOG2_DEEP each), active[3:0], last_tid[1:0], output registers issue_valid_o, thread_id, PC_select.
- Reset values: pc[n]=0, active=RESET_ACTIVE, last_tid=2'd3, issue_valid_o=0, thread_id=0, PC_select=0, active_o=RESET_ACTIVE.
- Eligible(n) = active[n] & ~stall_i[n] & ~(cfg_we_i & cfg_tid_i==n) & ~(redir_valid_i & redir_tid_i==n). A thread whose PC is written this cycle is never issued that cycle.
- Advance = ~issue_valid_o | issue_ready_i.
- On Advance: search last_tid+1, +2, +3, +4 (mod 4, last_tid itself checked last); first eligible thread g wins.
  - Winner: issue_valid_o<=1, thread_id<=g, PC_select<=pc[g], pc[g]<=pc[g]+1 (mod 2^INSTMEM_LOG2_DEEP, 255 wraps to 0 at default), last_tid<=g.
  - No eligible thread: issue_valid_o<=0; thread_id, PC_select, last_tid hold.
- No Advance (valid & ~ready): output registers and last_tid hold; no PC increment.
- Per-thread PC update priority (same thread, same cycle): cfg write > redirect > issue increment. Issue increment cannot collide with cfg/redirect (excluded from eligibility).
- Active update: cfg_we_i sets active[cfg_tid_i]; halt_i clears active[halt_tid_i]; cfg and halt to same thread same cycle -> cfg wins (thread active). Different threads -> both apply.
- Halt does not retract an already-registered issue slot; the thread is ineligible from the next selection.
- active_o = active register.

## Timing
- Selection latency: 1 cycle; state inputs sampled at edge k affect issue slot presented after edge k.
- All four active, no stalls, ready held high: after reset release, edges 1..8 present (tid,PC) = (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1).
- Single eligible thread: issues every cycle with consecutive PCs.
- Backpressure: slot stable for every cycle valid=1 & ready=0; issued thread's PC already incremented at the issuing edge.
- Async reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge; first issue is thread 0 on the first edge after deassertion (if eligible).

## Test plan
- Reset, all active, ready=1 -> tid sequence 0,1,2,3,0 with PCs 0,0,0,0,1; active_o=4'b1111.
- stall_i=4'b0010 held -> tid sequence 0,2,3,0,2,3; thread 1 PC remains 0; release stall -> thread 1 issued next in rotation order.
- Hold issue_ready_i=0 for 3 cycles while slot shows (2,5) -> thread_id=2, PC_select=5 stable for all 3 cycles; on release the next slot is thread 3.
- redir_valid_i for tid 1 to 0x40 on the cycle thread 1 would win -> thread 1 skipped that cycle; next thread 1 issue shows PC 0x40, then 0x41; cfg_we_i and redirect to the same thread in the same cycle -> cfg_pc_i wins.
- halt tid 0..2, cfg_we_i tid 3 pc 0xFF -> thread 3 issues 0xFF then 0x00 (wrap); halt tid 3 -> issue_valid_o=0; halt and cfg to the same thread in one cycle -> thread remains active.
- Assert rst_i asynchronously between edges mid-stream -> outputs zero and active_o=RESET_ACTIVE before the next edge; after release the rotation restarts at (0,0).

Source files
------------

// File: rtl/thread_scheduler.sv
// Round-robin issue scheduler for the four-thread barrel fetch stage.
// Owns per-thread PCs and active flags; presents one registered issue slot per cycle.
module thread_scheduler #(
    parameter int         INSTMEM_LOG2_DEEP = 8,
    parameter logic [3:0] RESET_ACTIVE      = 4'b1111
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [1:0]                   cfg_tid_i,
    input  logic [INSTMEM_LOG2_DEEP-1:0] cfg_pc_i,
    input  logic                         halt_i,
    input  logic [1:0]                   halt_tid_i,
    input  logic                         redir_valid_i,
    input  logic [1:0]                   redir_tid_i,
    input  logic [INSTMEM_LOG2_DEEP-1:0] redir_pc_i,
    input  logic [3:0]                   stall_i,
    input  logic                         issue_ready_i,
    output logic                         issue_valid_o,
    output logic [1:0]                   thread_id,
    output logic [INSTMEM_LOG2_DEEP-1:0] PC_select,
    output logic [3:0]                   active_o
);

    logic [INSTMEM_LOG2_DEEP-1:0] pc [4];
    logic [3:0]                   active;
    logic [1:0]                   last_tid;
    logic [3:0]                   eligible;
    logic                         found;
    logic [1:0]                   grant;
    logic [1:0]                   cand;
    logic                         advance;

    assign active_o = active;
    assign advance  = ~issue_valid_o | issue_ready_i;

    // A thread whose PC is being rewritten this cycle must not issue with the stale PC.
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            eligible[n] = active[n] & ~stall_i[n]
                        & ~(cfg_we_i & (cfg_tid_i == 2'(n)))
                        & ~(redir_valid_i & (redir_tid_i == 2'(n)));
        end
    end

    // Search starts one past the last winner; the last winner is considered last.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_tid + 2'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned n = 0; n < 4; n++) begin
                pc[n] <= '0;
            end
            active        <= RESET_ACTIVE;
            last_tid      <= 2'd3;
            issue_valid_o <= 1'b0;
            thread_id     <= '0;
            PC_select     <= '0;
        end else begin
            if (advance) begin
                if (found) begin
                    issue_valid_o <= 1'b1;
                    thread_id     <= grant;
                    PC_select     <= pc[grant];
                    pc[grant]     <= pc[grant] + INSTMEM_LOG2_DEEP'(1);
                    last_tid      <= grant;
                end else begin
                    issue_valid_o <= 1'b0;
                end
            end
            // Later assignments win: cfg over redirect over increment, cfg over halt.
            if (redir_valid_i) begin
                pc[redir_tid_i] <= redir_pc_i;
            end
            if (cfg_we_i) begin
                pc[cfg_tid_i] <= cfg_pc_i;
            end
            if (halt_i) begin
                active[halt_tid_i] <= 1'b0;
            end
            if (cfg_we_i) begin
                active[cfg_tid_i] <= 1'b1;
            end
        end
    end

endmodule
